// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a first-word-fall-through receive FIFO.
// Latency: byte appears on rx_data/rx_valid one cycle after its stop-bit sample.
// Backpressure: rx_ready pops the head; a full FIFO drops new bytes and pulses overflow.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          sys_clk,
    input  logic                          reset_n,
    input  logic                          uart_rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Reset synchronizer: assertion is immediate, release waits two edges.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n_s;

    // Shift a constant one in behind a released reset.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // Reset synchronizer register, cleared directly by the external reset.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= rst_sync_d;
    end

    assign rst_n_s = rst_sync_q[1];

    // ------------------------------------------------------------------
    // Serial line synchronizer; idle line is high so flops reset to one.
    // ------------------------------------------------------------------
    logic [1:0] rxd_sync_q, rxd_sync_d;
    logic       rxd_s;

    // Two-stage shift of the asynchronous serial input.
    always_comb begin
        rxd_sync_d = {rxd_sync_q[0], uart_rxd};
    end

    // Synchronizer register.
    always_ff @(posedge sys_clk or negedge rst_n_s) begin
        if (!rst_n_s) rxd_sync_q <= 2'b11;
        else          rxd_sync_q <= rxd_sync_d;
    end

    assign rxd_s = rxd_sync_q[1];

    // ------------------------------------------------------------------
    // Receive FSM: half-bit delay to the start-bit centre, then one full
    // bit time between samples.
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        push_req;
    logic        frame_err_q, frame_err_d;
    logic        cnt_zero;

    assign cnt_zero = (cnt_q == 16'd0);

    // Next-state, bit counter, sample capture and stop-bit outcome.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rxd_s) begin
                    cnt_d   = HALF_LOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (!rxd_s) begin
                    cnt_d   = BIT_LOAD;
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    // Line went back high before mid start bit: a glitch.
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    shreg_d[idx_q] = rxd_s;
                    cnt_d          = BIT_LOAD;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (rxd_s) begin
                    push_req = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    // Bad stop bit: discard and wait out a possible break.
                    frame_err_d = 1'b1;
                    state_d     = S_BREAK;
                end
            end
            S_BREAK: begin
                if (rxd_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge sys_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            idx_q       <= 3'd0;
            shreg_q     <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO (first-word fall-through, no write bypass).
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          pop, full, wr_en;

    assign rx_valid = (count_q != '0);
    assign full     = (count_q == DEPTH_CNT);
    assign pop      = rx_valid & rx_ready;

    // Pointer and occupancy update; a pop frees the slot a full-FIFO push needs.
    always_comb begin
        wr_en      = push_req & (~full | pop);
        overflow_d = push_req & full & ~pop;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
        if (wr_en && !pop)      count_d = count_q + (AW + 1)'(1);
        else if (!wr_en && pop) count_d = count_q - (AW + 1)'(1);
    end

    // FIFO control registers.
    always_ff @(posedge sys_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are don't-care until written, reads are masked.
    always_ff @(posedge sys_clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= shreg_q;
    end

    assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule
